fixed_point_accumulator: RTL and testbench
==========================================

# fixed_point_accumulator

Sequential signed fixed-point accumulator that sums a stream of operands. It receives each operand over a valid/ready handshake and folds it into a running sum through one instance of the carry-select adder. Optional saturation uses the adder's overflow and sign flags. It sits directly downstream of the adder in the ODE integration datapath and produces the accumulated derivative term for the state-update stage.

## Interface
- N, 16: data width, two's-complement fixed point; must be even and ≥ 4 (adder constraint)
- CNT_W, 8: width of the term-count field

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new accumulation; sampled only in IDLE
- len  in  CNT_W  number of terms to accumulate; sampled with start
- in_valid  in  1  operand present
- in_ready  out  1  accumulator accepts an operand this cycle
- in_data  in  N  operand
- in_sub  in  1  1: acc − in_data, 0: acc + in_data
- sum_out  out  N  accumulated result, valid while sum_valid
- sum_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- busy  out  1  high in ACCUM and DONE
- ovf_sticky  out  1  at least one add in this accumulation overflowed

## Operation
- Reset values: state = IDLE, acc = 0, remaining = 0, in_ready = 0, sum_valid = 0, busy = 0, ovf_sticky = 0, sum_out = 0.
- FSM states are IDLE, ACCUM and DONE.
- IDLE → ACCUM on start when len ≠ 0. At that edge: acc ← 0, remaining ← len, ovf_sticky ← 0.
- IDLE → DONE on start when len = 0. Same clears apply; the sum is 0.
- ACCUM: in_ready = 1.
  - On handshake (in_valid & in_ready): acc ← adder(acc, in_data, is_subtract = in_sub), remaining ← remaining − 1.
  - On overflow: ovf_sticky ← 1.
  - If remaining = 1 at handshake, go to DONE.
- DONE: sum_valid = 1 and sum_out = acc, both held stable until out_ready. When sum_valid & out_ready, go to IDLE.
- start is ignored outside IDLE. in_valid is ignored outside ACCUM, and no operand is consumed there.
- Arithmetic: N-bit two's complement; carry out is discarded. "True sign" means the adder's negative flag, which is overflow XOR result MSB.
- rst at any point aborts the accumulation immediately. Partial sums are discarded.

## Timing
- in_ready, sum_valid and busy are decoded from the registered state only. No combinational path exists from in_valid or out_ready to any output.
- Throughput is one operand per cycle with no bubbles.
- Last operand accepted at edge k → sum_valid high in cycle k+1.
- start at edge k → in_ready high in cycle k+1, or sum_valid high in cycle k+1 when len = 0.
- Result handshake at edge k → IDLE in cycle k+1. start is therefore accepted at the earliest in cycle k+1.
- The adder is a single combinational path within the cycle, so acc → adder → acc must meet one clock period.

## Configuration
- ACC_SATURATE_EN defined: on overflow, acc saturates. It goes to 1 followed by N−1 zeros (most negative) when the true sign is negative, otherwise to 0 followed by N−1 ones (most positive). Later terms continue from the saturated value.
- ACC_SATURATE_EN undefined: acc takes the wrapped adder result.
- ovf_sticky behaves identically in both builds.

## Structure
- A shared package `fixed_point_pkg` holds:
  - the state enum (IDLE/ACCUM/DONE)
  - the saturation constants, as functions of N: FXP_MAX, FXP_MIN
  - the default N
- There is one sub-module: the existing `carry_select_adder`, instantiated once. A is driven by acc, B by in_data, and is_subtract by in_sub. Its result, overflow_flag and negative outputs are consumed; carry is unused.
- All other logic (FSM, counter, acc/sum registers) is local to `fixed_point_accumulator`.

## Test plan
- len=3, operands +0x0010, +0x0020, −0x0005 back-to-back → sum_out=0x002B, ovf_sticky=0, sum_valid exactly 1 cycle after the third accept.
- len=2, +0x7000, +0x2000 → with ACC_SATURATE_EN: sum_out=0x7FFF, ovf_sticky=1; without: sum_out=0x9000, ovf_sticky=1.
- len=2, +0x8000, −0x0001 → with ACC_SATURATE_EN: 0x8000; without: 0x7FFF; ovf_sticky=1 in both builds.
- len=0 with start → sum_valid next cycle, sum_out=0x0000, in_ready never asserted, in_valid pulses not consumed.
- Backpressure case:
  - len=4 with in_valid gaps of 2 cycles gives the correct sum.
  - Hold out_ready=0 for 5 cycles: sum_out stays stable, and a start pulse during DONE is ignored.
  - Releasing out_ready returns the FSM to IDLE on the next cycle.
- Reset case:
  - Assert rst after 1 of 3 operands: in_ready, busy, sum_valid and ovf_sticky all drop to 0 immediately, asynchronously.
  - A following len=1 run with +0x0003 gives sum_out=0x0003.

Source files
------------

// File: rtl/fixed_point_accumulator_pkg.sv
// Shared types and constants for the fixed-point accumulator: FSM states,
// the default data width and the saturation limits as functions of N.
package fixed_point_pkg;

    localparam int FXP_N_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_e;

    // Limits are returned zero-extended to 64 bits; callers keep the low n bits.
    function automatic logic [63:0] fxp_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fxp_min(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/fixed_point_accumulator_carry_select_adder.sv
// Carry-select adder/subtractor: the low half ripples, the high half is
// precomputed for both carry-in values and selected by the low-half carry.
module carry_select_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_subtract,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         overflow_flag,
    output logic         negative
);
    localparam int H = N / 2;
    localparam int U = N - H;

    logic [N-1:0] b_eff_s;
    logic [H:0]   lo_s;
    logic [U:0]   hi0_s;
    logic [U:0]   hi1_s;

    assign b_eff_s = b ^ {N{is_subtract}};
    assign lo_s    = {1'b0, a[H-1:0]} + {1'b0, b_eff_s[H-1:0]} + {{H{1'b0}}, is_subtract};
    assign hi0_s   = {1'b0, a[N-1:H]} + {1'b0, b_eff_s[N-1:H]};
    assign hi1_s   = hi0_s + {{U{1'b0}}, 1'b1};

    assign {carry, result} = lo_s[H] ? {hi1_s, lo_s[H-1:0]} : {hi0_s, lo_s[H-1:0]};

    // Signed overflow: like-signed operands producing a result of the other sign.
    assign overflow_flag = (a[N-1] == b_eff_s[N-1]) & (result[N-1] != a[N-1]);
    assign negative      = overflow_flag ^ result[N-1];

endmodule

// File: rtl/fixed_point_accumulator.sv
// Signed fixed-point stream accumulator with valid/ready operand and result handshakes.
// Define ACC_SATURATE_EN to clamp the running sum on overflow instead of wrapping.
module fixed_point_accumulator
    import fixed_point_pkg::*;
#(
    parameter int N     = FXP_N_DEFAULT,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_sub,
    output logic [N-1:0]     sum_out,
    output logic             sum_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf_sticky
);
    localparam logic [63:0]      MAX_W   = fxp_max(N);
    localparam logic [63:0]      MIN_W   = fxp_min(N);
    localparam logic [N-1:0]     SAT_MAX = MAX_W[N-1:0];
    localparam logic [N-1:0]     SAT_MIN = MIN_W[N-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    acc_state_e       state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic [N-1:0]     sum_out_q, sum_out_d;
    logic             in_ready_q, in_ready_d;
    logic             sum_valid_q, sum_valid_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     add_res_s;
    logic [N-1:0]     acc_next_s;
    logic             add_ovf_s;
    logic             add_neg_s;
    logic             carry_unused_s;

    carry_select_adder #(.N(N)) u_adder (
        .a             (acc_q),
        .b             (in_data),
        .is_subtract   (in_sub),
        .result        (add_res_s),
        .carry         (carry_unused_s),
        .overflow_flag (add_ovf_s),
        .negative      (add_neg_s)
    );

`ifdef ACC_SATURATE_EN
    assign acc_next_s = add_ovf_s ? (add_neg_s ? SAT_MIN : SAT_MAX) : add_res_s;
`else
    assign acc_next_s = add_res_s;
`endif

    // Next-state, datapath and output decode; outputs follow the next state so they come straight from flops.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = {N{1'b0}};
                    rem_d   = len;
                    ovf_d   = 1'b0;
                    state_d = (len != {CNT_W{1'b0}}) ? ST_ACCUM : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (in_valid && in_ready_q) begin
                    acc_d = acc_next_s;
                    rem_d = rem_q - CNT_ONE;
                    ovf_d = ovf_q | add_ovf_s;
                    if (rem_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_ACCUM);
        sum_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        if (state_d == ST_DONE) begin
            sum_out_d = acc_d;
        end else begin
            sum_out_d = sum_out_q;
        end
    end

    // State and registered outputs; reset aborts any accumulation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= {N{1'b0}};
            rem_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            sum_out_q   <= {N{1'b0}};
            in_ready_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            ovf_q       <= ovf_d;
            sum_out_q   <= sum_out_d;
            in_ready_q  <= in_ready_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign sum_valid  = sum_valid_q;
    assign busy       = busy_q;
    assign ovf_sticky = ovf_q;
    assign sum_out    = sum_out_q;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Scoreboard bench for fixed_point_accumulator: stimulus pushes expected results,
// a monitor pops and compares on every result handshake.
module tb_fixed_point_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        in_sub = 1'b0;
    logic [15:0] sum_out;
    logic        sum_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        ovf_sticky;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_sum_q[$];
    logic        exp_ovf_q[$];

    fixed_point_accumulator #(.N(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sub     (in_sub),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && sum_valid && out_ready) begin
            if (exp_sum_q.size() == 0) begin
                chk("unexpected_result", 32'(sum_out), 32'hDEAD_BEEF);
            end else begin
                chk("sum_out", 32'(sum_out), 32'(exp_sum_q.pop_front()));
                chk("ovf_sticky", 32'(ovf_sticky), 32'(exp_ovf_q.pop_front()));
            end
        end
    end

    task automatic begin_run(input logic [7:0] l, input logic [15:0] es, input logic eo, input logic push);
        if (push) begin
            exp_sum_q.push_back(es);
            exp_ovf_q.push_back(eo);
        end
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_in_ready", 32'(in_ready), 32'(l != 8'd0));
        chk("start_sum_valid", 32'(sum_valid), 32'(l == 8'd0));
        chk("start_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
    endtask

    // Presents one operand and returns 1 time unit after the accepting edge.
    task automatic send(input logic [15:0] d, input logic s);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        if (!in_ready) begin
            @(negedge clk);
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sum_valid", 32'(sum_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        chk("rst_sum_out", 32'(sum_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // +0x10 +0x20 -0x5, back to back
        begin_run(8'd3, 16'h002B, 1'b0, 1'b1);
        send(16'h0010, 1'b0);
        send(16'h0020, 1'b0);
        send(16'h0005, 1'b1);
        @(negedge clk);
        chk("valid_after_last", 32'(sum_valid), 32'd1);
        @(posedge clk); #1;
        chk("idle_after_ack", 32'(busy), 32'd0);
        chk("valid_drop", 32'(sum_valid), 32'd0);

        // positive overflow
`ifdef ACC_SATURATE_EN
        begin_run(8'd2, 16'h7FFF, 1'b1, 1'b1);
`else
        begin_run(8'd2, 16'h9000, 1'b1, 1'b1);
`endif
        send(16'h7000, 1'b0);
        send(16'h2000, 1'b0);
        wait_idle();

        // negative overflow via subtract
`ifdef ACC_SATURATE_EN
        begin_run(8'd2, 16'h8000, 1'b1, 1'b1);
`else
        begin_run(8'd2, 16'h7FFF, 1'b1, 1'b1);
`endif
        send(16'h8000, 1'b0);
        send(16'h0001, 1'b1);
        wait_idle();

        // len = 0: in_valid pulses while in DONE must be ignored
        out_ready = 1'b0;
        begin_run(8'd0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
            @(negedge clk);
            chk("len0_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        wait_idle();

        // gaps between operands, then result backpressure
        begin_run(8'd4, 16'h10C3, 1'b0, 1'b1);
        send(16'h0100, 1'b0);
        repeat (2) @(posedge clk); #1;
        send(16'h0040, 1'b1);
        repeat (2) @(posedge clk); #1;
        send(16'h0003, 1'b0);
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h1000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                len   = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("hold_sum", 32'(sum_out), 32'h10C3);
            chk("hold_valid", 32'(sum_valid), 32'd1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd0);

        // asynchronous reset mid-run
        begin_run(8'd3, 16'h0000, 1'b0, 1'b0);
        send(16'h0007, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sum_valid", 32'(sum_valid), 32'd0);
        chk("arst_ovf", 32'(ovf_sticky), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        begin_run(8'd1, 16'h0003, 1'b0, 1'b1);
        send(16'h0003, 1'b0);
        wait_idle();

        chk("scoreboard_empty", 32'(exp_sum_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
